spi_eeprom_responder: RTL and testbench

SPI mode-0 responder that emulates a small serial EEPROM with the 25xx-style command set: WREN, WRDI, RDSR, READ and WRITE. It sits on the far end of the SPI link driven by `AXI_SPI_top` and is the synthesizable, ACLK-synchronous counterpart of the behavioural EEPROM model. It gives the bridge a target for system-level loopback and lets the FPGA image carry an on-chip SPI target. A local read port exposes the byte array to on-chip logic.

---
 rtl/spi_eeprom_responder.sv | 167 ++++++++++++++++
 tb/tb_spi_eeprom_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 target emulating a 25xx-style serial EEPROM with a local read port
module spi_eeprom_responder #(
    parameter int ADDR_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              SPI_SCK,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS,
    output logic              SPI_MISO,
    input  logic [ADDR_W-1:0] MEM_RADDR,
    output logic [7:0]        MEM_RDATA,
    output logic              WR_STROBE,
    output logic              WEL
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR_H, ADDR_L, WR_DATA, RD_DATA, STATUS, IGNORE} state_t;
    typedef enum logic [1:0] {ARM_NONE, ARM_SET, ARM_CLR} arm_t;

    state_t            state_q, state_d;
    arm_t              arm_q, arm_d;
    logic [2:0]        sck_q, sck_d, cs_q, cs_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]        mosi_q, mosi_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d, mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              miso_q, miso_d, load_q, load_d, is_rd_q, is_rd_d;
    logic              wrote_q, wrote_d, wel_q, wel_d, wr_strobe_q, wr_strobe_d;
    logic              mem_we;
    logic [7:0]        mem [2**ADDR_W];

    wire       sck_rise  = sck_q[1] & ~sck_q[2];
    wire       sck_fall  = ~sck_q[1] & sck_q[2];
    wire       cs_low    = ~cs_q[1];
    wire       cs_rise   = cs_q[1] & ~cs_q[2];
    wire [7:0] rx_byte   = {shift_q, mosi_q[1]};
    wire       byte_done = cs_low & sck_rise & (bit_cnt_q == 3'd7);
    wire       shifting  = (state_q == RD_DATA) || (state_q == STATUS);
    wire [7:0] tx_src    = (state_q == STATUS) ? {6'b0, wel_q, 1'b0} : mem[addr_q];

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: byte-driven phase sequencing, CS rise always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cs_low ? CMD : IDLE;
            CMD:     if (byte_done) state_d = (rx_byte == 8'h05) ? STATUS :
                                              (rx_byte == 8'h03 || rx_byte == 8'h02) ? ADDR_H : IGNORE;
            ADDR_H:  if (byte_done) state_d = ADDR_L;
            ADDR_L:  if (byte_done) state_d = is_rd_q ? RD_DATA : WR_DATA;
            default: ;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    // FSM outputs and datapath: sync, shift-in, address capture, writes, shift-out, WEL
    always_comb begin
        sck_d       = {sck_q[1:0], SPI_SCK};
        cs_d        = {cs_q[1:0], SPI_CS};
        mosi_d      = {mosi_q[0], SPI_MOSI};
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        load_d      = load_q;
        is_rd_d     = is_rd_q;
        wrote_d     = wrote_q;
        arm_d       = arm_q;
        wel_d       = wel_q;
        wr_strobe_d = 1'b0;
        mem_we      = 1'b0;
        mem_rdata_d = mem[MEM_RADDR];
        if (cs_low && sck_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (state_q == ADDR_H || state_q == ADDR_L) addr_d = ADDR_W'({addr_q, mosi_q[1]});
            if (state_q == IGNORE) arm_d = ARM_NONE;
        end
        if (byte_done) begin
            case (state_q)
                CMD: begin
                    arm_d   = (rx_byte == 8'h06) ? ARM_SET : (rx_byte == 8'h04) ? ARM_CLR : ARM_NONE;
                    is_rd_d = rx_byte == 8'h03;
                    load_d  = rx_byte == 8'h05;
                end
                ADDR_L:  load_d = is_rd_q;
                WR_DATA: if (wel_q) begin
                    mem_we      = ARESETn;
                    wr_strobe_d = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    wrote_d     = 1'b1;
                end
                RD_DATA: begin
                    addr_d = addr_q + 1'b1;
                    load_d = 1'b1;
                end
                STATUS:  load_d = 1'b1;
                default: ;
            endcase
        end
        if (cs_low && sck_fall && shifting) begin
            miso_d = load_q ? tx_src[7] : tx_q[7];
            tx_d   = load_q ? {tx_src[6:0], 1'b0} : {tx_q[6:0], 1'b0};
            load_d = 1'b0;
        end
        if (cs_rise) begin
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            load_d    = 1'b0;
            arm_d     = ARM_NONE;
            wrote_d   = 1'b0;
            wel_d     = wrote_q ? 1'b0 : (arm_q == ARM_SET) ? 1'b1 : (arm_q == ARM_CLR) ? 1'b0 : wel_q;
        end
    end

    // datapath registers; CS synchroniser resets high so reset release does not fake a CS edge
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            sck_q       <= 3'b000;
            cs_q        <= 3'b111;
            mosi_q      <= 2'b00;
            shift_q     <= 7'd0;
            bit_cnt_q   <= 3'd0;
            addr_q      <= '0;
            tx_q        <= 8'd0;
            miso_q      <= 1'b0;
            load_q      <= 1'b0;
            is_rd_q     <= 1'b0;
            wrote_q     <= 1'b0;
            arm_q       <= ARM_NONE;
            wel_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            mem_rdata_q <= 8'd0;
        end else begin
            sck_q       <= sck_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            load_q      <= load_d;
            is_rd_q     <= is_rd_d;
            wrote_q     <= wrote_d;
            arm_q       <= arm_d;
            wel_q       <= wel_d;
            wr_strobe_q <= wr_strobe_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // byte array; contents survive reset
    always_ff @(posedge ACLK) begin
        if (mem_we) mem[addr_q] <= rx_byte;
    end

    assign SPI_MISO  = miso_q;
    assign MEM_RDATA = mem_rdata_q;
    assign WR_STROBE = wr_strobe_q;
    assign WEL       = wel_q;
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb_spi_eeprom_responder: frame-level EEPROM model checked against directed and random SPI traffic
module tb_spi_eeprom_responder;
    logic       clk = 0;
    logic       ARESETn = 0, SPI_SCK = 0, SPI_MOSI = 0, SPI_CS = 1;
    logic       SPI_MISO, WR_STROBE, WEL;
    logic [7:0] MEM_RADDR = 0, MEM_RDATA;

    spi_eeprom_responder #(.ADDR_W(8)) dut (
        .ACLK(clk), .ARESETn(ARESETn), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
        .SPI_MISO(SPI_MISO), .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA),
        .WR_STROBE(WR_STROBE), .WEL(WEL)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, stb_cnt = 0, exp_stb, ntx;
    logic [7:0] tx [300];
    logic [7:0] rx [300];
    logic [7:0] want_rx [300];
    logic [7:0] mm [256];
    logic       m_wel = 0;

    always @(posedge clk) if (WR_STROBE === 1'b1) stb_cnt <= stb_cnt + 1;

    // single comparison point
    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        tx[ntx] = b;
        ntx++;
    endtask

    // SPI mode-0 master, SCK = ACLK/16; MISO sampled just before each rising edge
    task automatic frame(input int nbits, input bit raise);
        SPI_CS = 0;
        wait_n(8);
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = tx[i/8][7 - i%8];
            wait_n(8);
            rx[i/8] = {rx[i/8][6:0], SPI_MISO};
            SPI_SCK = 1;
            wait_n(8);
            SPI_SCK = 0;
        end
        if (raise) begin
            wait_n(8);
            SPI_CS = 1;
            SPI_MOSI = 0;
            wait_n(16);
        end
    endtask

    // expected MISO bytes, strobes and WEL/array effects of one whole frame
    task automatic model_frame(input int nbits);
        int nb, a;
        nb = nbits / 8;
        exp_stb = 0;
        for (int i = 0; i < 300; i++) want_rx[i] = 8'h00;
        if (nb == 0) return;
        a = int'(tx[2]);
        case (tx[0])
            8'h06: if (nbits == 8) m_wel = 1;
            8'h04: if (nbits == 8) m_wel = 0;
            8'h05: for (int i = 1; i < nb; i++) want_rx[i] = {6'b0, m_wel, 1'b0};
            8'h03: for (int i = 3; i < nb; i++) begin
                want_rx[i] = mm[a];
                a = (a + 1) % 256;
            end
            8'h02: begin
                for (int i = 3; i < nb; i++) if (m_wel) begin
                    mm[a] = tx[i];
                    a = (a + 1) % 256;
                    exp_stb++;
                end
                if (exp_stb > 0) m_wel = 0;
            end
            default: ;
        endcase
    endtask

    task automatic run(input int nbits, input string tag);
        int s0;
        model_frame(nbits);
        s0 = stb_cnt;
        frame(nbits, 1);
        for (int i = 0; i < nbits / 8; i++) chk($sformatf("%s miso[%0d]", tag, i), rx[i], want_rx[i]);
        chk({tag, " strobes"}, stb_cnt - s0, exp_stb);
        chk({tag, " wel"}, WEL, m_wel);
    endtask

    task automatic lport(input int a, input string tag);
        MEM_RADDR = 8'(a);
        wait_n(2);
        chk($sformatf("%s mem[%0h]", tag, a), MEM_RDATA, mm[a]);
    endtask

    task automatic wren();
        ntx = 0;
        put(8'h06);
        run(8, "wren");
    endtask

    initial begin
        int s0, kind, nd, nbits;
        wait_n(4);
        chk("rst miso", SPI_MISO, 0);
        chk("rst wel", WEL, 0);
        chk("rst strobe", WR_STROBE, 0);
        chk("rst rdata", MEM_RDATA, 0);
        ARESETn = 1;
        wait_n(4);

        s0 = stb_cnt;
        for (int i = 0; i < 8; i++) begin
            SPI_SCK = 1; wait_n(8);
            SPI_SCK = 0; wait_n(8);
            chk("cs_high miso", SPI_MISO, 0);
        end
        chk("cs_high strobes", stb_cnt - s0, 0);
        chk("cs_high wel", WEL, 0);

        wren();
        ntx = 0; put(8'h02); put(8'h00); put(8'h00);
        for (int i = 0; i < 256; i++) put(8'($urandom));
        run(259 * 8, "fill");
        for (int i = 0; i < 4; i++) lport($urandom_range(0, 255), "fill lport");

        wren();
        ntx = 0; put(8'h05); put(8'h00);
        run(16, "rdsr_wel1");
        chk("rdsr_wel1 const", rx[1], 8'h02);
        ntx = 0; put(8'h04);
        run(8, "wrdi");
        ntx = 0; put(8'h05); put(8'h00);
        run(16, "rdsr_wel0");
        chk("rdsr_wel0 const", rx[1], 8'h00);

        ntx = 0; put(8'h02); put(8'h00); put(8'hF0); put(8'hAA);
        run(32, "wr_nowel");
        lport(8'hF0, "wr_nowel");

        wren();
        ntx = 0; put(8'h02); put(8'h00); put(8'hF0); put(8'hAA); put(8'h55);
        run(40, "wr_two");
        lport(8'hF0, "wr_two");
        chk("wr_two const F0", MEM_RDATA, 8'hAA);
        lport(8'hF1, "wr_two");
        chk("wr_two const F1", MEM_RDATA, 8'h55);
        ntx = 0; put(8'h03); put(8'h00); put(8'hF0); put(8'h00); put(8'h00);
        run(40, "rd_two");
        chk("rd_two b0", rx[3], 8'hAA);
        chk("rd_two b1", rx[4], 8'h55);

        wren();
        ntx = 0; put(8'h02); put(8'h00); put(8'hFF); put(8'h11); put(8'h22);
        run(40, "wr_wrap");
        lport(8'hFF, "wr_wrap");
        lport(8'h00, "wr_wrap");
        ntx = 0; put(8'h03); put(8'h01); put(8'hFF); put(8'h00); put(8'h00);
        run(40, "rd_wrap");
        chk("rd_wrap b0", rx[3], 8'h11);
        chk("rd_wrap b1", rx[4], 8'h22);

        wren();
        ntx = 0; put(8'h02); put(8'h00); put(8'h10); put(8'hC3);
        run(29, "wr_partial");
        lport(8'h10, "wr_partial");

        ntx = 0; put(8'h03); put(8'h00); put(8'h20); put(8'h00);
        frame(28, 0);
        wait_n(6);
        ARESETn = 0;
        wait_n(1);
        chk("midrst miso", SPI_MISO, 0);
        chk("midrst wel", WEL, 0);
        m_wel = 0;
        wait_n(3);
        ARESETn = 1;
        wait_n(4);
        SPI_CS = 1;
        wait_n(16);
        ntx = 0; put(8'h05); put(8'h00);
        run(16, "post_rst rdsr");
        ntx = 0; put(8'h03); put(8'h00); put(8'h20); put(8'h00);
        run(32, "post_rst read");

        repeat (25) begin
            ntx = 0;
            kind = $urandom_range(0, 5);
            nd = $urandom_range(0, 3);
            case (kind)
                0, 1: begin
                    put(kind == 0 ? 8'h06 : 8'h04);
                    nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 8;
                    put(8'($urandom));
                end
                2: begin
                    put(8'h05);
                    for (int i = 0; i <= nd; i++) put(8'h00);
                    nbits = 8 * (2 + nd);
                end
                3, 4: begin
                    put(kind == 3 ? 8'h03 : 8'h02);
                    put(8'($urandom)); put(8'($urandom));
                    for (int i = 0; i < nd; i++) put(8'($urandom));
                    nbits = 8 * (3 + nd) - (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
                end
                default: begin
                    put(8'($urandom)); put(8'($urandom));
                    nbits = 16;
                end
            endcase
            run(nbits, $sformatf("rnd k%0d", kind));
            lport($urandom_range(0, 255), "rnd lport");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
